csr_host_driver: RTL

MMIO initiator that drives the host side of the AFU CSR protocol: it accepts simple read/write commands, turns them into single-cycle CCI-P-style MMIO requests (c0Rx fields) and collects matching MMIO read responses (c2Tx fields). It sits at the FIU-facing port of the CSR manager. Its users are on-chip test harnesses and the simulation loopback, which exercise AFU CSRs without a host. It serialises accesses, tags reads with rolling TIDs, enforces a response timeout and keeps saturating statistics.

---
 rtl/csr_host_pkg.sv | 22 ++
 rtl/sat_counter.sv | 19 +
 rtl/csr_host_driver.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/csr_host_pkg.sv
// Shared types and constants for the CSR host driver and anything that talks to it.
// Type widths mirror the CCI-P TID and MMIO address fields.
package csr_host_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        DONE
    } t_csr_host_state;

    typedef logic [8:0]  t_csr_host_tid;
    typedef logic [15:0] t_csr_host_addr;

    localparam logic [63:0] ALL_ONES_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

    // MMIO accesses from this driver are always 64-bit, so the address is forced even.
    function automatic t_csr_host_addr align_addr(input t_csr_host_addr addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the driver statistics; sticks at all ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (inc && (value != {WIDTH{1'b1}})) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/csr_host_driver.sv
// Host-side MMIO initiator: serialises read/write commands into single-cycle CSR
// requests, matches read responses by TID, times out lost reads and keeps statistics.
module csr_host_driver
    import csr_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 512,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_is_write,
    input  logic [15:0]           cmd_addr,
    input  logic [63:0]           cmd_wdata,

    output logic                  rsp_valid,
    output logic [63:0]           rsp_data,
    output logic                  rsp_timeout,

    output logic                  mmio_rd_valid,
    output logic                  mmio_wr_valid,
    output logic [15:0]           mmio_addr,
    output logic [8:0]            mmio_tid,
    output logic [63:0]           mmio_wdata,

    input  logic                  mmio_rsp_valid,
    input  logic [8:0]            mmio_rsp_tid,
    input  logic [63:0]           mmio_rsp_data,

    output logic [STAT_WIDTH-1:0] stat_reads,
    output logic [STAT_WIDTH-1:0] stat_writes,
    output logic [STAT_WIDTH-1:0] stat_timeouts,
    output logic [STAT_WIDTH-1:0] stat_tid_mismatch
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    t_csr_host_state state;
    t_csr_host_tid   next_tid;
    logic            cur_write;
    logic [CNT_W-1:0] wait_cnt;

    logic rsp_match;
    logic expire;
    logic inc_reads;
    logic inc_writes;
    logic inc_timeouts;
    logic inc_mismatch;

    // mmio_tid holds the TID of the outstanding read, so it doubles as the match key.
    assign rsp_match    = mmio_rsp_valid && (state == WAIT_RSP) && (mmio_rsp_tid == mmio_tid);
    assign expire       = (state == WAIT_RSP) && (wait_cnt == LAST_WAIT) && !rsp_match;
    assign inc_reads    = (state == ISSUE) && !cur_write;
    assign inc_writes   = (state == ISSUE) && cur_write;
    assign inc_timeouts = expire;
    assign inc_mismatch = mmio_rsp_valid && !rsp_match;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            cur_write     <= 1'b0;
            next_tid      <= '0;
            wait_cnt      <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_timeout   <= 1'b0;
            mmio_rd_valid <= 1'b0;
            mmio_wr_valid <= 1'b0;
            mmio_addr     <= '0;
            mmio_tid      <= '0;
            mmio_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state         <= ISSUE;
                        cmd_ready     <= 1'b0;
                        cur_write     <= cmd_is_write;
                        mmio_rd_valid <= !cmd_is_write;
                        mmio_wr_valid <= cmd_is_write;
                        mmio_addr     <= align_addr(cmd_addr);
                        mmio_tid      <= next_tid;
                        mmio_wdata    <= cmd_wdata;
                    end
                end
                ISSUE: begin
                    mmio_rd_valid <= 1'b0;
                    mmio_wr_valid <= 1'b0;
                    next_tid      <= next_tid + 9'd1;
                    wait_cnt      <= '0;
                    if (cur_write) begin
                        state       <= DONE;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b0;
                    end else begin
                        state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // A matching response in the expiry cycle still wins over the timeout.
                    if (rsp_match) begin
                        state       <= DONE;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= mmio_rsp_data;
                        rsp_timeout <= 1'b0;
                    end else if (expire) begin
                        state       <= DONE;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= ALL_ONES_DATA;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    cmd_ready   <= 1'b1;
                    rsp_valid   <= 1'b0;
                    rsp_timeout <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_reads (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_reads),
        .value (stat_reads)
    );

    sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_writes (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_writes),
        .value (stat_writes)
    );

    sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_timeouts (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_timeouts),
        .value (stat_timeouts)
    );

    sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_tid_mismatch (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_mismatch),
        .value (stat_tid_mismatch)
    );

endmodule
